// File: rtl/alu_acc_pkg.sv
// Shared types for the accumulator/ALU engine: opcode encodings and FSM states.
package alu_acc_pkg;

    typedef enum logic [2:0] {
        OP_LOAD = 3'b000,
        OP_ADD  = 3'b001,
        OP_SUB  = 3'b010,
        OP_AND  = 3'b011,
        OP_MUL  = 3'b100,
        OP_DIV  = 3'b101,
        OP_NOP  = 3'b110,
        OP_NOP2 = 3'b111
    } op_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/alu_acc_seq_if.sv
// Control-unit <-> accumulator engine bus: op issue handshake, operands, result and flags.
interface alu_acc_seq_if #(
    parameter int WIDTH = 4
);
    logic                 start;
    logic [2:0]           op;
    logic [WIDTH-1:0]     operand_a;
    logic [WIDTH-1:0]     operand_b;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   acc_data;
    logic                 zero_flag;
    logic                 sign_flag;
    logic                 carry_flag;
    logic                 div_by_zero;

    modport master (
        output start, op, operand_a, operand_b,
        input  busy, done, acc_data, zero_flag, sign_flag, carry_flag, div_by_zero
    );

    modport slave (
        input  start, op, operand_a, operand_b,
        output busy, done, acc_data, zero_flag, sign_flag, carry_flag, div_by_zero
    );
endinterface

// File: rtl/alu_acc_addsub.sv
// WIDTH-bit adder/subtractor with a (WIDTH+1)-bit result; res[WIDTH] is carry on add
// and borrow on subtract. Shared by ADD, SUB, the MUL add-step and the DIV trial-subtract.
module alu_acc_addsub #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH:0]   res
);
    // Zero-extend both operands so the top bit captures carry out / borrow.
    assign res = sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
endmodule

// File: rtl/alu_acc_seq.sv
// Accumulator/ALU engine: single-cycle LOAD/ADD/SUB/AND, multi-cycle shift-add MUL and
// restoring DIV under a two-state FSM with start/busy/done handshake.
// Optional feature macro: ALU_ACC_DIV_EN (enables DIV; otherwise DIV behaves as NOP).
module alu_acc_seq
    import alu_acc_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_p,
    alu_acc_seq_if.slave     bus
);
    localparam int CW = $clog2(WIDTH + 1);

    state_t               state;
    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH-1:0]     b_q;
    logic                 busy_r, done_r, zf_r, sf_r, cf_r;
    op_t                  op_in;
    logic [WIDTH-1:0]     as_a, as_b;
    logic                 as_sub;
    logic [WIDTH:0]       as_res;
    logic [2*WIDTH-1:0]   sc_acc, iter_acc;
    logic                 sc_carry;
`ifdef ALU_ACC_DIV_EN
    logic                 run_div;
    logic                 dbz_r;
`endif

    assign op_in = op_t'(bus.op);

    // Route the shared adder: A op B when idle, iteration step operands during RUN.
    always_comb begin
        as_a   = acc[WIDTH-1:0];
        as_b   = bus.operand_b;
        as_sub = (op_in == OP_SUB);
        if (state == RUN) begin
            as_b   = b_q;
            as_a   = acc[2*WIDTH-1:WIDTH];
            as_sub = 1'b0;
`ifdef ALU_ACC_DIV_EN
            if (run_div) begin
                // Trial subtract works on the high half after the left shift.
                as_a   = acc[2*WIDTH-2:WIDTH-1];
                as_sub = 1'b1;
            end
`endif
        end
    end

    alu_acc_addsub #(.WIDTH(WIDTH)) u_addsub (
        .a   (as_a),
        .b   (as_b),
        .sub (as_sub),
        .res (as_res)
    );

    // Single-cycle result and carry for the op presented on the bus.
    always_comb begin
        sc_acc   = acc;
        sc_carry = 1'b0;
        case (op_in)
            OP_LOAD:        sc_acc = {{WIDTH{1'b0}}, bus.operand_a};
            OP_ADD, OP_SUB: begin
                sc_acc   = {{WIDTH{1'b0}}, as_res[WIDTH-1:0]};
                sc_carry = as_res[WIDTH];
            end
            OP_AND:         sc_acc = {{WIDTH{1'b0}}, acc[WIDTH-1:0] & bus.operand_b};
            default:        sc_acc = acc;
        endcase
    end

    // Next accumulator value for one MUL or DIV iteration.
    always_comb begin
        if (acc[0])
            iter_acc = {as_res[WIDTH], as_res[WIDTH-1:0], acc[WIDTH-1:1]};
        else
            iter_acc = {1'b0, acc[2*WIDTH-1:1]};
`ifdef ALU_ACC_DIV_EN
        if (run_div) begin
            if (!as_res[WIDTH])
                iter_acc = {as_res[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            else
                iter_acc = {acc[2*WIDTH-2:0], 1'b0};
        end
`endif
    end

    // FSM, iteration counter, accumulator and flag registers.
    always_ff @(posedge clk) begin
        if (reset_p) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            b_q    <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            zf_r   <= 1'b0;
            sf_r   <= 1'b0;
            cf_r   <= 1'b0;
`ifdef ALU_ACC_DIV_EN
            run_div <= 1'b0;
            dbz_r   <= 1'b0;
`endif
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
`ifdef ALU_ACC_DIV_EN
                        dbz_r <= 1'b0;
`endif
                        case (op_in)
                            OP_LOAD, OP_ADD, OP_SUB, OP_AND: begin
                                acc    <= sc_acc;
                                zf_r   <= (sc_acc == '0);
                                sf_r   <= sc_acc[WIDTH-1];
                                cf_r   <= sc_carry;
                                done_r <= 1'b1;
                            end
                            OP_MUL: begin
                                acc    <= {{WIDTH{1'b0}}, acc[WIDTH-1:0]};
                                b_q    <= bus.operand_b;
                                cnt    <= CW'(WIDTH);
                                busy_r <= 1'b1;
                                state  <= RUN;
`ifdef ALU_ACC_DIV_EN
                                run_div <= 1'b0;
`endif
                            end
`ifdef ALU_ACC_DIV_EN
                            OP_DIV: begin
                                if (bus.operand_b == '0) begin
                                    dbz_r  <= 1'b1;
                                    done_r <= 1'b1;
                                end else begin
                                    acc     <= {{WIDTH{1'b0}}, acc[WIDTH-1:0]};
                                    b_q     <= bus.operand_b;
                                    cnt     <= CW'(WIDTH);
                                    busy_r  <= 1'b1;
                                    run_div <= 1'b1;
                                    state   <= RUN;
                                end
                            end
`endif
                            default: done_r <= 1'b1;
                        endcase
                    end
                end
                RUN: begin
                    acc <= iter_acc;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state  <= IDLE;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        zf_r   <= (iter_acc == '0);
                        sf_r   <= iter_acc[2*WIDTH-1];
                        cf_r   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.acc_data   = acc;
    assign bus.zero_flag  = zf_r;
    assign bus.sign_flag  = sf_r;
    assign bus.carry_flag = cf_r;
`ifdef ALU_ACC_DIV_EN
    assign bus.div_by_zero = dbz_r;
`else
    assign bus.div_by_zero = 1'b0;
`endif
endmodule

// File: doc/alu_acc_seq.md
# alu_acc_seq

Parametrised accumulator/ALU engine for the basys3/cora CPU datapath. It holds a 2*WIDTH accumulator and executes LOAD/ADD/SUB/AND in one cycle. MUL (shift-add) and DIV (restoring) run as multi-cycle sequences under an internal FSM with a start/busy/done handshake. It replaces the fixed 4-bit accumulator/ALU pair; the control unit drives opcodes and operands directly instead of per-half select lines.

## Interface
- WIDTH, 4, operand width; accumulator is 2*WIDTH (WIDTH ≥ 2)
- clk  in  1  system clock, rising edge
- reset_p  in  1  synchronous, active-high reset
- start  in  1  issue op; sampled only when busy=0
- op  in  3  000 LOAD, 001 ADD, 010 SUB, 011 AND, 100 MUL, 101 DIV, 110/111 NOP
- operand_a  in  WIDTH  LOAD data
- operand_b  in  WIDTH  register operand B for ADD/SUB/AND/MUL/DIV
- busy  out  1  multi-cycle op in progress
- done  out  1  one-cycle pulse: result and flags valid
- acc_data  out  2*WIDTH  accumulator {high, low}
- zero_flag, sign_flag, carry_flag  out  1 each
- div_by_zero  out  1  set on DIV with B=0

## Operation
- A = acc_data[WIDTH-1:0], B = operand_b; all arithmetic unsigned.
- LOAD: acc ← {0, operand_a}; carry_flag ← 0.
- ADD: {c, s} = A + B; acc ← {0, s}; carry_flag ← c.
- SUB: {c, s} = A − B; acc ← {0, s}; carry_flag ← borrow (1 iff A < B).
- AND: acc ← {0, A & B}; carry_flag ← 0.
- NOP: no acc/flag change; done still pulses.
- MUL: init acc ← {0, A}. Each iteration: if acc[0], {c, high} = high + B, else c=0; then acc ← {c, high, low} >> 1. After WIDTH iterations acc = A*B. carry_flag ← 0.
- DIV: init acc ← {0, A}. Each iteration: acc ← acc << 1; trial = high − B; if no borrow, high ← trial and acc[0] ← 1. After WIDTH iterations high = remainder, low = quotient. carry_flag ← 0.
- FSM: IDLE → (start & op∈{MUL,DIV}) → RUN; RUN stays while cnt≠0 and returns to IDLE on the last iteration. cnt is a $clog2(WIDTH+1)-bit down-counter loaded with WIDTH.
- Flags update only on the edge that raises done. zero_flag = (acc == 0) over all 2*WIDTH bits. sign_flag = acc[2*WIDTH-1] for MUL/DIV, acc[WIDTH-1] otherwise.
- div_by_zero holds its value until the next accepted start, which clears it.

## Timing
- Reset: acc_data 0, all flags 0, div_by_zero 0, busy 0, done 0, cnt 0, FSM IDLE. Reset overrides start.
- Reset mid-RUN aborts the operation. No done pulse is issued and the partial result is discarded.
- Single-cycle ops: start sampled at edge E. Result, flags and done=1 are visible after E; latency 1.
- MUL/DIV: edge E initialises acc and sets busy=1. Edges E+1..E+WIDTH run the iterations. At E+WIDTH busy → 0 and done → 1 with the final result; latency WIDTH+1 edges.
- start while busy=1 is ignored and not queued. start during the done cycle is accepted, so back-to-back ops are allowed.
- acc_data is registered and changes during RUN. Consumers sample it only when done=1 or when idle.

## Configuration
- ALU_ACC_DIV_EN defined: DIV is implemented as above. DIV with B=0 completes in one cycle: done=1, div_by_zero=1, acc and flags unchanged, busy stays 0.
- ALU_ACC_DIV_EN undefined: DIV decodes as NOP with one-cycle done and acc unchanged. div_by_zero is tied 0, and the division compare/restore logic is not synthesised.

## Structure
- alu_acc_pkg: op_t enum (OP_LOAD … OP_NOP encodings) and state_t (IDLE, RUN).
- Sub-module alu_acc_addsub: parametrised WIDTH+1 adder/subtractor with carry/borrow out. It is shared by ADD, SUB, MUL add-step and DIV trial-subtract; the top holds FSM, counter, acc and flags.

## Test plan (WIDTH=4)
- LOAD 5 then ADD B=3 → acc 0x08, carry 0, zero 0, done pulses one cycle after each start.
- LOAD 0xC, ADD B=7 → acc 0x03, carry 1. Then SUB B=5 → acc 0x0E, carry (borrow) 1, sign 1.
- LOAD 13, MUL B=11 → busy high for 4 cycles, done at edge E+4, acc 0x8F, sign 1. A start pulsed while busy is ignored.
- LOAD 13, DIV B=4 → acc 0x13 (remainder 1, quotient 3) after 4 busy cycles.
- With ALU_ACC_DIV_EN: LOAD 9, DIV B=0 → done after 1 cycle, div_by_zero 1, acc 0x09. The next ADD clears div_by_zero.
- MUL in progress, reset_p asserted at iteration 2 → next cycle acc 0, busy 0, no done pulse, flags 0.
